lector_gray_binario: RTL and testbench
======================================

LECTOR_GRAY_BINARIO -- requirements
Module: lector_gray_binario

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the Gray/binary word width (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single system clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port Gray, input, WIDTH, an absolute-encoder Gray code that is asynchronous to clk.
REQ-005 The block SHALL have port Habilitar, input, 1, the enable for position acceptance.
REQ-006 The block SHALL have port Binario, output, WIDTH, the registered binary position.
REQ-007 The block SHALL have port Valido, output, 1, a one-cycle pulse on each accepted position.
REQ-008 The block SHALL have port Direccion, output, 1, the direction of the last accepted step (1 = up, 0 = down), registered.
REQ-009 The block SHALL have port Error, output, 1, a one-cycle pulse on each illegal transition.
REQ-010 The block SHALL have port ContErrores, output, 8, a saturating count of illegal transitions.

Function
REQ-011 Gray SHALL pass through a two-flop synchronizer (s1, s2) before any use.
REQ-012 The block SHALL keep a last-accepted Gray register (gq) and an FSM with states INIT and RUN.
REQ-013 Binary conversion SHALL be b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] XOR g[i], applied to s2.
REQ-014 In INIT with Habilitar=1, the block SHALL load gq<=s2 and Binario<=bin(s2), pulse Valido, leave Direccion and Error unchanged, and go to RUN.
REQ-015 In RUN with Habilitar=1 and s2==gq, all outputs SHALL hold with Valido=0 and Error=0.
REQ-016 In RUN with Habilitar=1 and popcount(s2 XOR gq)==1, the block SHALL update gq and Binario and pulse Valido; Direccion SHALL be 1 iff bin(s2)==bin(gq)+1 mod 2^WIDTH, else 0.
REQ-017 Wrap-around SHALL be treated as a legal step: bin 2^WIDTH-1 -> 0 gives Direccion=1, and 0 -> 2^WIDTH-1 gives Direccion=0.
REQ-018 In RUN with Habilitar=1 and popcount(s2 XOR gq)>1, the block SHALL pulse Error, keep Valido=0, resynchronize by loading gq<=s2 and Binario<=bin(s2), hold Direccion, and increment ContErrores, saturating at 255.
REQ-019 Only one Error pulse SHALL occur per illegal jump; the resynchronized gq suppresses repeats while the input stays stable.
REQ-020 With Habilitar=0 in either state, the block SHALL hold gq, Binario, Direccion, ContErrores and the FSM state; Valido and Error SHALL be 0; the synchronizer SHALL keep sampling.
REQ-021 On re-enable, s2 SHALL be compared against the held gq under the REQ-015..018 rules.
REQ-022 Latency SHALL be fixed: a Gray value stable before rising edge k is captured in s1 at k and in s2 at k+1, and Binario/Valido/Error are updated at edge k+2.
REQ-023 Valido and Error SHALL never be asserted in the same cycle.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from Gray to any output.

Reset
REQ-025 On rst_n=0, independent of clk, the block SHALL clear s1, s2, gq, Binario, Direccion, Valido, Error and ContErrores to 0 and set the FSM to INIT.
REQ-026 Reset asserted mid-operation SHALL abort any pending update, with no Valido or Error pulse emitted.
REQ-027 After rst_n deasserts, the first load SHALL follow REQ-014 and SHALL never count as an error.

Verification
REQ-028 Reset release with Gray=0000 and Habilitar=1 -> one Valido pulse, Binario=0000, Error=0, ContErrores=0.
REQ-029 Gray 0000->0001->0011->0010, each value held 4 cycles -> Binario 1, 2, 3, each with one Valido pulse two edges after s1 capture, and Direccion=1.
REQ-030 Gray 0010->0011, then 1000->0000 (bin 15->0) -> Binario=2 with Direccion=0, then Binario=0 with Direccion=1.
REQ-031 Gray 0011->0110 -> one Error pulse, Valido=0, Binario=0100, ContErrores increments by 1; holding 0110 for 10 more cycles gives no further pulses.
REQ-032 260 illegal jumps -> ContErrores=255 and stays at 255; Habilitar=0 while Gray changes -> outputs frozen, no pulses.
REQ-033 rst_n pulsed low mid-walk -> all outputs 0 immediately; after release, the REQ-028 behaviour is reproduced.

Source files
------------

// File: rtl/lector_gray_binario.sv
// -----------------------------------------------------------------------------
// lector_gray_binario
//
// Reads an absolute-encoder Gray code that is asynchronous to clk. The code
// is synchronized, converted to binary, and checked against the last accepted
// position. Single-bit Gray steps are accepted as legal moves. Multi-bit jumps
// are flagged as errors, and the reader then resynchronizes to the new value.
//
// Ports
//   clk          system clock; all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   Gray         encoder Gray code, asynchronous to clk
//   Habilitar    enable for position acceptance
//   Binario      registered binary position
//   Valido       one-cycle pulse on each accepted position
//   Direccion    direction of last accepted step (1 = up, 0 = down)
//   Error        one-cycle pulse on each illegal transition
//   ContErrores  saturating count of illegal transitions
//
// FSM states
//   state | meaning
//   ------+-----------------------------------------------------------------
//   INIT  | no reference position yet; first enabled sample is loaded as-is
//   RUN   | reference held in gq; new samples are checked against it
// -----------------------------------------------------------------------------
module lector_gray_binario #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Gray,
    input  logic             Habilitar,
    output logic [WIDTH-1:0] Binario,
    output logic             Valido,
    output logic             Direccion,
    output logic             Error,
    output logic [7:0]       ContErrores
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] s1, s2;
    logic [WIDTH-1:0] gq, gq_n;
    logic [WIDTH-1:0] bin_n;
    logic             valido_n, direccion_n, error_n;
    logic [7:0]       cont_n;

    logic [WIDTH-1:0] bin_s2, bin_gq, diff;
    logic             one_bit, step_up;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign bin_s2 = gray2bin(s2);
    assign bin_gq = gray2bin(gq);
    assign diff   = s2 ^ gq;
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign one_bit = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
    // Modular compare, so 2^WIDTH-1 -> 0 counts as an upward step.
    assign step_up = (bin_s2 == bin_gq + 1'b1);

    always_comb begin
        state_n     = state;
        gq_n        = gq;
        bin_n       = Binario;
        direccion_n = Direccion;
        cont_n      = ContErrores;
        valido_n    = 1'b0;
        error_n     = 1'b0;
        if (Habilitar) begin
            case (state)
                INIT: begin
                    gq_n     = s2;
                    bin_n    = bin_s2;
                    valido_n = 1'b1;
                    state_n  = RUN;
                end
                RUN: begin
                    if (one_bit) begin
                        gq_n        = s2;
                        bin_n       = bin_s2;
                        valido_n    = 1'b1;
                        direccion_n = step_up;
                    end else if (diff != '0) begin
                        // Resync to the new value so a stable input errors once.
                        gq_n    = s2;
                        bin_n   = bin_s2;
                        error_n = 1'b1;
                        if (ContErrores != 8'hFF) begin
                            cont_n = ContErrores + 8'd1;
                        end
                    end
                end
                default: state_n = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '0;
            s2          <= '0;
            gq          <= '0;
            Binario     <= '0;
            Valido      <= 1'b0;
            Direccion   <= 1'b0;
            Error       <= 1'b0;
            ContErrores <= 8'd0;
        end else begin
            s1          <= Gray;
            s2          <= s1;
            gq          <= gq_n;
            Binario     <= bin_n;
            Valido      <= valido_n;
            Direccion   <= direccion_n;
            Error       <= error_n;
            ContErrores <= cont_n;
        end
    end

endmodule

// File: tb/tb_lector_gray_binario.sv
module tb_lector_gray_binario;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] Gray;
    logic         Habilitar;
    logic [W-1:0] Binario;
    logic         Valido;
    logic         Direccion;
    logic         Error;
    logic [7:0]   ContErrores;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lector_gray_binario #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Gray       (Gray),
        .Habilitar  (Habilitar),
        .Binario    (Binario),
        .Valido     (Valido),
        .Direccion  (Direccion),
        .Error      (Error),
        .ContErrores(ContErrores)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies a legal step and checks the two-edge latency and the pulse width.
    task automatic apply_legal(input logic [W-1:0] g, input logic [W-1:0] eb,
                               input logic ed, input string name);
        Gray = g;
        step();
        step();
        vectors++;
        if (Valido !== 1'b0) begin
            miscompares++;
            $display("FAIL %s early: Valido got %b expected 0", name, Valido);
        end
        step();
        vectors++;
        if ({Valido, Error, Binario, Direccion} !== {1'b1, 1'b0, eb, ed}) begin
            miscompares++;
            $display("FAIL %s: V/E/Bin/Dir got %b/%b/%h/%b expected 1/0/%h/%b",
                     name, Valido, Error, Binario, Direccion, eb, ed);
        end
        step();
        vectors++;
        if (Valido !== 1'b0) begin
            miscompares++;
            $display("FAIL %s width: Valido got %b expected 0", name, Valido);
        end
    endtask

    task automatic test_reset();
        int pulses;
        int errs;
        rst_n = 1'b0;
        Gray = '0;
        Habilitar = 1'b1;
        repeat (3) step();
        vectors++;
        if ({Binario, Valido, Direccion, Error, ContErrores} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: Bin/V/D/E/Cnt got %h/%b/%b/%b/%0d expected all 0",
                     Binario, Valido, Direccion, Error, ContErrores);
        end
        rst_n = 1'b1;
        pulses = 0;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Valido === 1'b1) pulses++;
            if (Error === 1'b1) errs++;
        end
        vectors++;
        if (pulses != 1 || errs != 0) begin
            miscompares++;
            $display("FAIL reset_first_load: pulses got %0d/%0d expected 1 Valido/0 Error",
                     pulses, errs);
        end
        vectors++;
        if (Binario !== 4'h0 || ContErrores !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_first_value: Bin/Cnt got %h/%0d expected 0/0",
                     Binario, ContErrores);
        end
    endtask

    task automatic test_walk_up();
        apply_legal(4'b0001, 4'd1, 1'b1, "walk_1");
        apply_legal(4'b0011, 4'd2, 1'b1, "walk_2");
        apply_legal(4'b0010, 4'd3, 1'b1, "walk_3");
    endtask

    task automatic test_direction_wrap();
        apply_legal(4'b0011, 4'd2,  1'b0, "down_2");
        apply_legal(4'b0001, 4'd1,  1'b0, "down_1");
        apply_legal(4'b0000, 4'd0,  1'b0, "down_0");
        apply_legal(4'b1000, 4'd15, 1'b0, "wrap_0_to_15");
        apply_legal(4'b0000, 4'd0,  1'b1, "wrap_15_to_0");
    endtask

    task automatic test_illegal_jump();
        int pulses;
        apply_legal(4'b0001, 4'd1, 1'b1, "pre_ill_1");
        apply_legal(4'b0011, 4'd2, 1'b1, "pre_ill_2");
        Gray = 4'b0110;
        step();
        step();
        vectors++;
        if (Error !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_early: Error got %b expected 0", Error);
        end
        step();
        vectors++;
        if ({Error, Valido, Binario, Direccion, ContErrores} !==
            {1'b1, 1'b0, 4'b0100, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL illegal_jump: E/V/Bin/Dir/Cnt got %b/%b/%h/%b/%0d expected 1/0/4/1/1",
                     Error, Valido, Binario, Direccion, ContErrores);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (Error === 1'b1 || Valido === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0 || ContErrores !== 8'd1) begin
            miscompares++;
            $display("FAIL illegal_no_repeat: pulses/Cnt got %0d/%0d expected 0/1",
                     pulses, ContErrores);
        end
    endtask

    task automatic test_saturation();
        int errs;
        int vals;
        int both;
        errs = 0;
        vals = 0;
        both = 0;
        for (int j = 1; j <= 260; j++) begin
            Gray = (j % 2 == 1) ? 4'b0000 : 4'b0110;
            for (int c = 0; c < 3; c++) begin
                step();
                if (Error === 1'b1) errs++;
                if (Valido === 1'b1) vals++;
                if (Error === 1'b1 && Valido === 1'b1) both++;
            end
            if (j == 200) begin
                vectors++;
                if (ContErrores !== 8'd201) begin
                    miscompares++;
                    $display("FAIL count_mid: ContErrores got %0d expected 201", ContErrores);
                end
            end
        end
        vectors++;
        if (errs != 260 || vals != 0 || both != 0) begin
            miscompares++;
            $display("FAIL sat_pulses: Error/Valido/both got %0d/%0d/%0d expected 260/0/0",
                     errs, vals, both);
        end
        vectors++;
        if (ContErrores !== 8'd255 || Binario !== 4'b0100) begin
            miscompares++;
            $display("FAIL saturation: Cnt/Bin got %0d/%h expected 255/4",
                     ContErrores, Binario);
        end
    endtask

    task automatic test_disable();
        int pulses;
        Habilitar = 1'b0;
        pulses = 0;
        Gray = 4'b0111;
        repeat (4) begin step(); if (Valido === 1'b1 || Error === 1'b1) pulses++; end
        Gray = 4'b0000;
        repeat (4) begin step(); if (Valido === 1'b1 || Error === 1'b1) pulses++; end
        Gray = 4'b0010;
        repeat (4) begin step(); if (Valido === 1'b1 || Error === 1'b1) pulses++; end
        vectors++;
        if (pulses != 0 || {Binario, Direccion, ContErrores} !== {4'b0100, 1'b1, 8'd255}) begin
            miscompares++;
            $display("FAIL disable_frozen: pulses/Bin/Dir/Cnt got %0d/%h/%b/%0d expected 0/4/1/255",
                     pulses, Binario, Direccion, ContErrores);
        end
        Habilitar = 1'b1;
        step();
        vectors++;
        if ({Valido, Error, Binario, Direccion, ContErrores} !==
            {1'b1, 1'b0, 4'd3, 1'b0, 8'd255}) begin
            miscompares++;
            $display("FAIL reenable: V/E/Bin/Dir/Cnt got %b/%b/%h/%b/%0d expected 1/0/3/0/255",
                     Valido, Error, Binario, Direccion, ContErrores);
        end
        step();
        vectors++;
        if (Valido !== 1'b0) begin
            miscompares++;
            $display("FAIL reenable_width: Valido got %b expected 0", Valido);
        end
    endtask

    task automatic test_reset_mid_walk();
        int pulses;
        int errs;
        Gray = 4'b0011;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({Binario, Valido, Direccion, Error, ContErrores} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: Bin/V/D/E/Cnt got %h/%b/%b/%b/%0d expected all 0",
                     Binario, Valido, Direccion, Error, ContErrores);
        end
        Gray = 4'b0000;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (Valido === 1'b1 || Error === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_abort: pulses got %0d expected 0", pulses);
        end
        rst_n = 1'b1;
        pulses = 0;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Valido === 1'b1) pulses++;
            if (Error === 1'b1) errs++;
        end
        vectors++;
        if (pulses != 1 || errs != 0 || Binario !== 4'h0 || ContErrores !== 8'd0) begin
            miscompares++;
            $display("FAIL rerelease: V/E pulses/Bin/Cnt got %0d/%0d/%h/%0d expected 1/0/0/0",
                     pulses, errs, Binario, ContErrores);
        end
    endtask

    initial begin
        test_reset();
        test_walk_up();
        test_direction_wrap();
        test_illegal_jump();
        test_saturation();
        test_disable();
        test_reset_mid_walk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
